// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE control FSM.
// Digits decrement once every TICK_DIV cycles in RUN and stop at 00.
module bcd_timer_ctrl #(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] presc_q, presc_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       do_count;
    logic [3:0] load_tens, load_ones;

    assign load_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    assign load_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tens_q    <= '0;
            ones_q    <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Only the highest-priority asserted control acts; an ignored one still blocks lower ones.
    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        presc_d  = '0;
        do_count = 1'b0;

        if (clear) begin
            state_d = IDLE;
            tens_d  = '0;
            ones_d  = '0;
        end else if (load) begin
            if (state_q == RUN) begin
                do_count = 1'b1;
            end else begin
                state_d = IDLE;
                tens_d  = load_tens;
                ones_d  = load_ones;
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start) begin
            case (state_q)
                IDLE:    state_d = ((tens_q == 4'd0) && (ones_q == 4'd0)) ? DONE : RUN;
                PAUSED:  state_d = RUN;
                RUN:     do_count = 1'b1;
                default: state_d = state_q;
            endcase
        end else if (state_q == RUN) begin
            do_count = 1'b1;
        end

        if (do_count) begin
            if (presc_q == TICK_LAST) begin
                presc_d = '0;
                if (ones_q != 4'd0) begin
                    ones_d = ones_q - 4'd1;
                end else begin
                    ones_d = 4'd9;
                    tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                end
                if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
                    state_d = DONE;
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    always_comb begin
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE) && (state_q != DONE);
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: directed scenarios plus random control traffic,
// checked every cycle against an integer-valued countdown model.
module tb_bcd_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    int m_state = M_IDLE;
    int m_val   = 0;
    int m_cnt   = 0;
    bit m_done  = 1'b0;

    bcd_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .tens     (tens),
        .ones     (ones),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int clampValue(input logic [7:0] lv);
        int t;
        int o;
        t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return t * 10 + o;
    endfunction

    // Countdown seen as a single integer value plus a cycles-in-RUN counter.
    task automatic modelStep(input bit r_n, input bit ld, input logic [7:0] lv,
                             input bit st_in, input bit ps, input bit cl);
        int prev;
        prev = m_state;
        if (!r_n) begin
            m_state = M_IDLE; m_val = 0; m_cnt = 0;
        end else if (cl) begin
            m_state = M_IDLE; m_val = 0; m_cnt = 0;
        end else if (ld && m_state != M_RUN) begin
            m_state = M_IDLE; m_val = clampValue(lv); m_cnt = 0;
        end else if (!ld && ps && m_state == M_RUN) begin
            m_state = M_PAUSED; m_cnt = 0;
        end else if (!ld && !ps && st_in && m_state == M_IDLE) begin
            m_state = (m_val == 0) ? M_DONE : M_RUN;
            m_cnt = 0;
        end else if (!ld && !ps && st_in && m_state == M_PAUSED) begin
            m_state = M_RUN; m_cnt = 0;
        end else if (m_state == M_RUN) begin
            m_cnt++;
            if (m_cnt == TICK_DIV) begin
                m_cnt = 0;
                m_val--;
                if (m_val == 0) m_state = M_DONE;
            end
        end
        m_done = r_n && (m_state == M_DONE) && (prev != M_DONE);
    endtask

    task automatic applyStimulus(input bit r_n, input bit ld, input logic [7:0] lv,
                                 input bit st_in, input bit ps, input bit cl);
        rst_n    = r_n;
        load     = ld;
        load_val = lv;
        start    = st_in;
        pause    = ps;
        clear    = cl;
        @(posedge clk);
        modelStep(r_n, ld, lv, st_in, ps, cl);
        #1;
        checkOutput("tens", tens, m_val / 10);
        checkOutput("ones", ones, m_val % 10);
        checkOutput("running", running, (m_state == M_RUN) ? 1 : 0);
        checkOutput("done", done, m_done ? 1 : 0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; load = 0; load_val = 0; start = 0; pause = 0; clear = 0;

        applyStimulus(0, 1, 8'h77, 1, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("reset_digits", {tens, ones}, 8'h00);
        checkOutput("reset_running", running, 0);

        // Count 12 down to 00 with a borrow at 10 -> 09.
        applyStimulus(1, 1, 8'h12, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(4);
        checkOutput("cnt_11", {tens, ones}, 8'h11);
        idleCycles(4);
        checkOutput("cnt_10", {tens, ones}, 8'h10);
        idleCycles(4);
        checkOutput("cnt_09", {tens, ones}, 8'h09);
        idleCycles(36);
        checkOutput("cnt_00", {tens, ones}, 8'h00);
        checkOutput("cnt_done_pulse", done, 1);
        checkOutput("cnt_running_low", running, 0);
        idleCycles(3);
        checkOutput("cnt_done_single", done, 0);
        checkOutput("cnt_hold_00", {tens, ones}, 8'h00);

        // Pause then resume restarts the prescaler.
        applyStimulus(1, 1, 8'h05, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(6);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        idleCycles(20);
        checkOutput("pause_hold", {tens, ones}, 8'h04);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(3);
        checkOutput("resume_early", {tens, ones}, 8'h04);
        idleCycles(1);
        checkOutput("resume_dec", {tens, ones}, 8'h03);

        // Start on 00 goes straight to DONE.
        applyStimulus(1, 0, 8'h00, 0, 0, 1);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_running", running, 0);
        idleCycles(1);
        checkOutput("zero_done_off", done, 0);

        // Clamping and clear-over-load priority.
        applyStimulus(1, 1, 8'hFB, 0, 0, 0);
        checkOutput("clamp_99", {tens, ones}, 8'h99);
        applyStimulus(1, 1, 8'hA3, 0, 0, 0);
        checkOutput("clamp_93", {tens, ones}, 8'h93);
        applyStimulus(1, 1, 8'h45, 0, 0, 1);
        checkOutput("clear_over_load", {tens, ones}, 8'h00);

        // Load ignored in RUN; pause wins over start.
        applyStimulus(1, 1, 8'h20, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(2);
        applyStimulus(1, 1, 8'h55, 0, 0, 0);
        idleCycles(1);
        checkOutput("run_load_ignored", {tens, ones}, 8'h19);
        applyStimulus(1, 0, 8'h00, 1, 1, 0);
        checkOutput("pause_over_start", running, 0);

        // Reset mid-count, then a normal short run.
        applyStimulus(1, 1, 8'h50, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(10);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_mid_digits", {tens, ones}, 8'h00);
        checkOutput("rst_mid_done", done, 0);
        idleCycles(5);
        applyStimulus(1, 1, 8'h03, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        idleCycles(12);
        checkOutput("after_rst_done", done, 1);

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] lv;
            lv = 8'($urandom);
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 19) == 0), lv,
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 10, clock cycles per count decrement (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  load load_val into the two digit counters.
REQ-005 load_val  input  8  [7:4] tens BCD digit, [3:0] ones BCD digit.
REQ-006 start  input  1  begin counting from IDLE, or resume from PAUSED.
REQ-007 pause  input  1  suspend counting while in RUN.
REQ-008 clear  input  1  force digits to 00 and return to IDLE.
REQ-009 tens  output  4  tens digit, 0..9.
REQ-010 ones  output  4  ones digit, 0..9.
REQ-011 running  output  1  high while the FSM is in RUN.
REQ-012 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 The block SHALL sequence a two-digit cascaded mod-10 down-counter through four FSM states: IDLE, RUN, PAUSED and DONE.
REQ-014 Control inputs are sampled at every rising edge with priority clear > load > pause > start; each edge acts only on the highest-priority asserted input.
REQ-015 clear, any state: digits <= 00, prescaler <= 0, next state IDLE.
REQ-016 load, legal in IDLE, PAUSED and DONE: digits <= load_val, next state IDLE; ignored in RUN.
REQ-017 Any load_val digit greater than 9 SHALL be clamped to 9 on load (e.g. 8'hA3 loads 93).
REQ-018 start in IDLE with a nonzero value: next state RUN, prescaler <= 0.
REQ-019 start in IDLE with value 00: next state DONE, done pulses in that cycle.
REQ-020 start in PAUSED: next state RUN, prescaler <= 0, digits unchanged.
REQ-021 start in RUN or DONE is ignored.
REQ-022 pause in RUN: next state PAUSED, digits frozen; pause in other states is ignored.
REQ-023 Prescaler behaviour in RUN: increments each cycle; on the edge where prescaler == TICK_DIV-1, it resets to 0 and the digits decrement.
REQ-024 Decrement latency: the first decrement occurs TICK_DIV edges after the edge that sampled start.
REQ-025 Decrement rule: if ones > 0, ones - 1; else ones <= 9 and tens - 1 (borrow, wrap 0 -> 9).
REQ-026 When a decrement produces 00, the same edge moves the FSM to DONE; done is high for exactly one cycle and running is low from that cycle on.
REQ-027 DONE holds 00 until clear or load; the digits never wrap below 00.
REQ-028 The prescaler is held at 0 in every state except RUN.
REQ-029 running SHALL be a registered decode of state == RUN; done SHALL be registered and glitch-free.
REQ-030 ones and tens SHALL never hold a value above 9 in any state.

Reset
REQ-031 rst_n low at a rising edge: state IDLE, tens = 0, ones = 0, prescaler = 0, running = 0, done = 0.
REQ-032 Reset SHALL override every control input.
REQ-033 Reset asserted mid-RUN SHALL abort the count; after release the block waits in IDLE for a load or start.
REQ-034 Outputs SHALL be valid and reset-valued in the cycle after the reset edge.

Verification (bench uses TICK_DIV = 4)
REQ-035 load 8'h12, then start -> after 4 cycles 11; after 8 cycles 10; after 12 cycles 09 (borrow); after 48 cycles from start 00, one-cycle done, running drops.
REQ-036 load 8'h05, start, pause after 6 cycles -> digits hold 04 for 20 cycles; start -> next decrement to 03 exactly 4 cycles later.
REQ-037 start with digits 00 -> DONE next cycle, done pulse 1 cycle, digits 00, running never high.
REQ-038 load 8'hFB -> digits 99; clear and load asserted together -> 00, IDLE.
REQ-039 load asserted during RUN -> ignored, count continues; pause and start asserted together in RUN -> PAUSED.
REQ-040 rst_n low for 1 cycle mid-count from 50 -> 00, IDLE, running 0, no done pulse; a later load 8'h03 plus start completes normally after 12 cycles.
